instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//   Writer side of the instruction memory: accepts a byte stream of program code, packs
//   each 4 bytes little-endian (first byte -> [7:0]) into a 32-bit instruction and issues
//   one write per word at byte addresses 0,4,8,... Holds the core off (busy) while loading,
//   so a fetch of adr N afterwards returns exactly the bytes streamed at offsets N..N+3.
// PARAMETERS
//   SIZE    64   instruction memory capacity in bytes; loads over SIZE bytes are rejected
//   ADDR_W  64   width of wr_addr, equal to the fetch address width
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   start      in   1       begin a load; sampled only in IDLE
//   num_words  in   16      instructions to load; sampled with start
//   s_valid    in   1       byte stream valid
//   s_data     in   8       byte stream data
//   s_ready    out  1       loader accepts a byte this cycle
//   wr_en      out  1       write strobe to instruction memory, one cycle per word
//   wr_addr    out  ADDR_W  byte address of the word being written, multiple of 4
//   wr_data    out  32      packed instruction
//   busy       out  1       load in progress; core must stay stalled
//   done       out  1       one-cycle pulse at end of a successful load
//   err        out  1       sticky: last start requested num_words*4 > SIZE
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, byte index/word count/address 0, partial word lost.
//   Reset mid-load: same; no wr_en is produced for a partial word.
//   All outputs registered or decoded from state register only (Moore); no comb. path in->out.
//   States:
//     IDLE    s_ready=0. start & num_words==0 -> DONE. start & num_words*4>SIZE -> err=1, stay.
//             start otherwise -> err=0, word_cnt=0, byte_idx=0, COLLECT.
//     COLLECT s_ready=1. Byte accepted iff s_valid & s_ready; stored in lane byte_idx.
//             4th byte (byte_idx==3) accepted -> WRITE next cycle; byte_idx wraps to 0.
//     WRITE   wr_en=1 exactly one cycle, wr_addr=word_cnt*4, wr_data=assembled word, s_ready=0.
//             word_cnt+1==num_words -> DONE, else word_cnt++ -> COLLECT.
//     DONE    done=1 for one cycle -> IDLE.
//   busy=1 in COLLECT, WRITE, DONE. start while busy ignored (no restart, no param change).
//   err clears only on next accepted start; err never asserts busy or writes.
//   Latency: 4th-byte handshake edge -> wr_en high next cycle; last wr_en -> done next cycle.
//   Peak throughput: 4 bytes per 5 cycles (one non-ready cycle in WRITE).
//   s_data ignored when not accepted; s_valid may drop at any time without losing bytes.
//   wr_addr/wr_data hold last values outside WRITE; wr_en is the only write qualifier.
//   num_words*4 computed in 18 bits to avoid overflow in the SIZE comparison.
// TESTING
//   1 reset; start num_words=1; bytes 03,21,C1,00 back-to-back -> one wr_en, wr_addr=0,
//     wr_data=32'h00C12103; done pulse next cycle; busy falls with done->IDLE.
//   2 num_words=5, 20 program bytes with random s_valid gaps -> writes at 0,4,8,12,16 of
//     00C12103,002100B3,00102623,00C02183,FE310AE3; exactly 5 wr_en, one done.
//   3 SIZE=64, num_words=17 -> err=1, s_ready/wr_en/busy stay 0; then start num_words=1 ->
//     err=0, load completes normally.
//   4 start num_words=0 -> DONE next cycle, done=1 one cycle, no wr_en, s_ready never 1.
//   5 reset raised after 2 bytes of word 0 -> outputs 0 immediately (async); after release
//     and restart, 4 bytes AA,BB,CC,DD -> wr_addr=0, wr_data=32'hDDCCBBAA.
//   6 start pulsed during COLLECT of word 1 of a 3-word load -> ignored; 3 writes at 0,4,8.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader_if
//  Description : Byte-stream, control and instruction-memory write bundle
//                between the program source and instr_mem_loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_mem_loader_if #(
    parameter int ADDR_W = 64
);
    logic              start;
    logic [15:0]       num_words;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;

    // Program source / core side: drives the stream and load request.
    modport master (
        output start, num_words, s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    // Loader side.
    modport slave (
        input  start, num_words, s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Packs a byte stream little-endian into 32-bit instructions
//                and writes them to instruction memory at 0,4,8,...; keeps
//                the core stalled (busy) for the duration of the load.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem_loader #(
    parameter int SIZE   = 64,
    parameter int ADDR_W = 64    // must match the interface instance ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_mem_loader_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [17:0] SIZE_BYTES = 18'(SIZE);

    state_t            state;
    state_t            next_state;
    logic [1:0]        byte_idx;
    logic [15:0]       word_cnt;
    logic [15:0]       num_words_q;
    logic [23:0]       partial;      // lanes 0..2 of the word being assembled
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              err_q;

    // Request size in bytes; 18 bits so num_words*4 cannot wrap before the compare.
    logic [17:0] req_bytes;
    logic        too_big;
    logic        accept;
    logic        last_byte;
    logic        last_word;

    assign req_bytes = {bus.num_words, 2'b00};
    assign too_big   = (req_bytes > SIZE_BYTES);
    assign accept    = (state == COLLECT) && bus.s_valid;
    assign last_byte = accept && (byte_idx == 2'd3);
    assign last_word = (({1'b0, word_cnt} + 17'd1) == {1'b0, num_words_q});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_words == 16'd0) begin
                        next_state = DONE;
                    end else if (!too_big) begin
                        next_state = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = last_word ? DONE : COLLECT;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: load parameters, byte packing, write address/data, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx    <= 2'd0;
            word_cnt    <= 16'd0;
            num_words_q <= 16'd0;
            partial     <= 24'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (too_big) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q       <= 1'b0;
                            num_words_q <= bus.num_words;
                            word_cnt    <= 16'd0;
                            byte_idx    <= 2'd0;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: partial[7:0]   <= bus.s_data;
                            2'd1: partial[15:8]  <= bus.s_data;
                            2'd2: partial[23:16] <= bus.s_data;
                            default: begin
                                // Word complete: present it for the WRITE cycle.
                                wr_data_q <= {bus.s_data, partial};
                                wr_addr_q <= ADDR_W'({word_cnt, 2'b00});
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_cnt <= word_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register only.
    assign bus.s_ready = (state == COLLECT);
    assign bus.wr_en   = (state == WRITE);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Randomized self-checking bench for instr_mem_loader against
//                a byte-queue packing model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    instr_mem_loader_if #(.ADDR_W(64)) bus ();

    instr_mem_loader #(.SIZE(64), .ADDR_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference data: bytes streamed for the current load, and observations.
    logic [7:0]  tx[$];
    logic [63:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          acc4_cyc[$];
    int          done_cnt;
    int          done_cyc;
    int          sready_seen;
    int          start_cyc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (bus.wr_en) begin
            obs_addr.push_back(bus.wr_addr);
            obs_data.push_back(bus.wr_data);
            obs_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.s_ready) sready_seen++;
        if (!reset && !bus.busy)
            check_val("idle_quiet", {61'd0, bus.s_ready, bus.wr_en, bus.done}, 64'd0);
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        acc4_cyc.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        sready_seen = 0;
    endtask

    task automatic do_start(input logic [15:0] nw);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.num_words = nw;
        start_cyc     = cyc;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.num_words = 16'($urandom);
    endtask

    // Push every byte of tx through the handshake; optionally pulse start
    // while byte poke_at is pending.
    task automatic stream(input int gap_pct, input int poke_at);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < tx.size() && guard < 2000) begin
            bus.s_valid = ($urandom_range(99) >= gap_pct);
            bus.s_data  = bus.s_valid ? tx[i] : 8'($urandom);
            if (i == poke_at) begin
                bus.start     = 1'b1;
                bus.num_words = 16'd9;
            end
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            if (acc && (i % 4 == 3)) acc4_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (acc) i++;
            guard++;
        end
        bus.s_valid = 1'b0;
        if (guard >= 2000) check_val("stream_timeout", 64'd1, 64'd0);
    endtask

    task automatic finish_load(input int nw);
        int g = 0;
        while (done_cnt == 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        if (g >= 100) check_val("done_timeout", 64'd1, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("wr_count", 64'(obs_addr.size()), 64'(nw));
        for (int j = 0; j < nw && j < obs_addr.size(); j++) begin
            check_val("wr_addr", obs_addr[j], 64'(4 * j));
            check_val("wr_data", {32'd0, obs_data[j]},
                      {32'd0, tx[4*j+3], tx[4*j+2], tx[4*j+1], tx[4*j]});
            if (j < acc4_cyc.size())
                check_val("wr_latency", 64'(obs_cyc[j]), 64'(acc4_cyc[j] + 1));
        end
        check_val("done_count", 64'(done_cnt), 64'd1);
        if (nw == 0)
            check_val("done_latency", 64'(done_cyc), 64'(start_cyc + 1));
        else if (obs_cyc.size() > 0)
            check_val("done_latency", 64'(done_cyc), 64'(obs_cyc[obs_cyc.size()-1] + 1));
        check_val("busy_after", {63'd0, bus.busy}, 64'd0);
        check_val("err_after", {63'd0, bus.err}, 64'd0);
    endtask

    task automatic run_load(input int nw, input int gap_pct, input int poke_at);
        clear_obs();
        do_start(16'(nw));
        stream(gap_pct, poke_at);
        finish_load(nw);
    endtask

    task automatic fill_random(input int nw);
        tx.delete();
        for (int k = 0; k < 4 * nw; k++) tx.push_back(8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {bus.s_ready, bus.wr_en, bus.busy, bus.done, bus.err} == 5'd0 &&
                       bus.wr_addr == 64'd0 && bus.wr_data == 32'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.num_words = 16'd0;
        bus.s_valid   = 1'b0;
        bus.s_data    = 8'd0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        @(negedge clk);
        reset = 1'b0;

        // Single word, back-to-back bytes.
        tx = '{8'h03, 8'h21, 8'hC1, 8'h00};
        run_load(1, 0, -1);
        if (obs_data.size() > 0) check_val("t1_word", {32'd0, obs_data[0]}, 64'h00C12103);

        // Five words with random gaps.
        tx = '{8'h03, 8'h21, 8'hC1, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00,
               8'h23, 8'h26, 8'h10, 8'h00, 8'h83, 8'h21, 8'hC0, 8'h00,
               8'hE3, 8'h0A, 8'h31, 8'hFE};
        run_load(5, 40, -1);
        if (obs_data.size() == 5) check_val("t2_last_word", {32'd0, obs_data[4]}, 64'hFE310AE3);

        // Oversize request rejected, then a normal load clears err.
        clear_obs();
        do_start(16'd17);
        repeat (5) @(posedge clk);
        #1;
        check_val("oversize_err", {63'd0, bus.err}, 64'd1);
        check_val("oversize_busy", {63'd0, bus.busy}, 64'd0);
        check_val("oversize_ready", 64'(sready_seen), 64'd0);
        check_val("oversize_writes", 64'(obs_addr.size()), 64'd0);
        fill_random(1);
        run_load(1, 20, -1);

        // Zero-word load.
        tx.delete();
        run_load(0, 0, -1);
        check_val("zero_ready", 64'(sready_seen), 64'd0);

        // Asynchronous reset in the middle of word 0.
        clear_obs();
        do_start(16'd1);
        tx = '{8'h11, 8'h22};
        stream(0, -1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        check_val("reset_no_write", 64'(obs_addr.size()), 64'd0);
        tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, 0, -1);
        if (obs_data.size() > 0) check_val("t5_word", {32'd0, obs_data[0]}, 64'hDDCCBBAA);

        // Start pulsed while collecting word 1 of a 3-word load.
        fill_random(3);
        run_load(3, 30, 5);

        // Full-capacity load and random loads.
        fill_random(16);
        run_load(16, 25, -1);
        for (int t = 0; t < 6; t++) begin
            int nw;
            nw = $urandom_range(1, 16);
            fill_random(nw);
            run_load(nw, $urandom_range(0, 60), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
